// File: rtl/pb_gen_pkg.sv
// Shared types and constants for the pushbutton bounce generator.
package pb_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BOUNCE,
        SETTLE,
        DONE
    } pb_state_t;

    localparam int                LFSR_W        = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every clock out of reset.
module lfsr16
    import pb_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
    input  logic              clock,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            state <= SEED;
        else if (state[0])
            state <= (state >> 1) ^ LFSR_TAPS;
        else
            state <= state >> 1;
    end

endmodule

// File: rtl/pb_bounce_gen.sv
// Pushbutton bounce transmitter: edge to target, 2*n_bounce glitches with
// LFSR-spaced gaps, then a settle period and a one-cycle done pulse.
//
//   state  | meaning
//   IDLE   | PB holds last value, waiting for start
//   BOUNCE | counting gaps, toggling PB at each expiry
//   SETTLE | PB stable, counting settle cycles
//   DONE   | done=1 for one cycle, start ignored
module pb_bounce_gen
    import pb_gen_pkg::*;
#(
    parameter int          CNT_W      = 16,
    parameter int          MIN_GAP    = 20,
    parameter int          GAP_RAND_W = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             target,
    input  logic [3:0]       n_bounce,
    input  logic [CNT_W-1:0] settle_len,
    output logic             PB,
    output logic             busy,
    output logic             done,
    output logic [3:0]       bounce_cnt
);

    localparam longint GAP_MAX = longint'(MIN_GAP) + (longint'(1) << GAP_RAND_W) - 1;
    localparam logic [LFSR_W-1:0] RAND_MASK = LFSR_W'((64'd1 << GAP_RAND_W) - 64'd1);

    if (MIN_GAP < 1 || GAP_RAND_W < 0 || GAP_RAND_W > LFSR_W ||
        GAP_MAX >= (longint'(1) << CNT_W) || LFSR_SEED == 16'h0000) begin : g_bad_cfg
        $error("pb_bounce_gen: illegal gap/seed configuration");
    end

    pb_state_t         state_q, state_d;
    logic              pb_q, pb_d;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic [CNT_W-1:0]  slen_q, slen_d;
    logic [4:0]        tog_q, tog_d;
    logic [LFSR_W-1:0] lfsr;
    logic [CNT_W-1:0]  gap_val;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clock (clock),
        .rst_n (rst_n),
        .state (lfsr)
    );

    // Gap is sampled from the current LFSR value at every counter load.
    assign gap_val = CNT_W'(MIN_GAP) + CNT_W'(lfsr & RAND_MASK);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pb_q     <= 1'b0;
            gap_q    <= '0;
            settle_q <= '0;
            slen_q   <= '0;
            tog_q    <= '0;
        end else begin
            state_q  <= state_d;
            pb_q     <= pb_d;
            gap_q    <= gap_d;
            settle_q <= settle_d;
            slen_q   <= slen_d;
            tog_q    <= tog_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pb_d     = pb_q;
        gap_d    = gap_q;
        settle_d = settle_q;
        slen_d   = slen_q;
        tog_d    = tog_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pb_d   = target;
                    slen_d = (settle_len == '0) ? CNT_W'(1) : settle_len;
                    tog_d  = {n_bounce, 1'b0};
                    if (n_bounce != 4'd0) begin
                        gap_d   = gap_val;
                        state_d = BOUNCE;
                    end else begin
                        settle_d = slen_d;
                        state_d  = SETTLE;
                    end
                end
            end
            BOUNCE: begin
                if (gap_q <= CNT_W'(1)) begin
                    pb_d  = ~pb_q;
                    tog_d = tog_q - 5'd1;
                    if (tog_q != 5'd1) begin
                        gap_d = gap_val;
                    end else begin
                        settle_d = slen_q;
                        state_d  = SETTLE;
                    end
                end else begin
                    gap_d = gap_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                // Count reaches zero one cycle before leaving, so done lands settle_len+1 after the last edge.
                if (settle_q == '0)
                    state_d = DONE;
                else
                    settle_d = settle_q - CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign PB         = pb_q;
    assign busy       = (state_q == BOUNCE) || (state_q == SETTLE);
    assign done       = (state_q == DONE);
    assign bounce_cnt = 4'((tog_q + 5'd1) >> 1);

endmodule

// File: tb/tb_pb_bounce_gen.sv
// Bench for pb_bounce_gen: a fixed-gap and a random-gap instance share stimulus
// and are compared every cycle against an event-time reference model.
module tb_pb_bounce_gen;

    localparam int          MIN_GAP = 20;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          BIG     = 32'h3fff_ffff;

    logic        clock = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        target = 1'b0;
    logic [3:0]  n_bounce = 4'd0;
    logic [15:0] settle_len = 16'd0;

    logic       pb_f, busy_f, done_f, pb_r, busy_r, done_r;
    logic [3:0] bc_f, bc_r;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clock = ~clock;

    pb_bounce_gen #(.CNT_W(16), .MIN_GAP(MIN_GAP), .GAP_RAND_W(0), .LFSR_SEED(SEED)) dut_fix (
        .clock(clock), .rst_n(rst_n), .start(start), .target(target),
        .n_bounce(n_bounce), .settle_len(settle_len),
        .PB(pb_f), .busy(busy_f), .done(done_f), .bounce_cnt(bc_f)
    );

    pb_bounce_gen #(.CNT_W(16), .MIN_GAP(MIN_GAP), .GAP_RAND_W(5), .LFSR_SEED(SEED)) dut_rnd (
        .clock(clock), .rst_n(rst_n), .start(start), .target(target),
        .n_bounce(n_bounce), .settle_len(settle_len),
        .PB(pb_r), .busy(busy_r), .done(done_r), .bounce_cnt(bc_r)
    );

    // Reference model: PB level, toggles left, time of next toggle and of done.
    logic [15:0] m_lfsr;
    int  m_mask [2] = '{0, 31};
    bit  m_pb [2];
    int  m_togs [2];
    int  m_next [2];
    int  m_settle [2];
    int  m_done_at [2];
    int  start_at [2];
    int  done_n [2];
    int  done_cyc [2];
    bit  pb_prev [2] = '{1'b0, 1'b0};
    int  edges [2][$];
    int  saved_gaps [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int gap_of(input int i, input logic [15:0] lf);
        return MIN_GAP + (int'(lf) & m_mask[i]);
    endfunction

    task automatic model_reset();
        m_lfsr = SEED;
        for (int i = 0; i < 2; i++) begin
            m_pb[i]      = 1'b0;
            m_togs[i]    = 0;
            m_next[i]    = 0;
            m_done_at[i] = -10;
        end
    endtask

    task automatic model_edge(input int i, input logic [15:0] lf);
        if (start && cyc >= m_done_at[i] + 2) begin
            m_pb[i]     = target;
            m_togs[i]   = 2 * int'(n_bounce);
            m_settle[i] = (settle_len == 16'd0) ? 1 : int'(settle_len);
            start_at[i] = cyc;
            done_n[i]   = 0;
            edges[i].delete();
            if (m_togs[i] > 0) begin
                m_next[i]    = cyc + gap_of(i, lf);
                m_done_at[i] = BIG;
            end else begin
                m_done_at[i] = cyc + m_settle[i] + 1;
            end
        end else if (m_togs[i] > 0 && cyc == m_next[i]) begin
            m_pb[i] = !m_pb[i];
            m_togs[i]--;
            if (m_togs[i] > 0)
                m_next[i] = cyc + gap_of(i, lf);
            else
                m_done_at[i] = cyc + m_settle[i] + 1;
        end
    endtask

    task automatic compare_all();
        logic       pb_s [2];
        logic       busy_s [2];
        logic       done_s [2];
        logic [3:0] bc_s [2];
        pb_s   = '{pb_f, pb_r};
        busy_s = '{busy_f, busy_r};
        done_s = '{done_f, done_r};
        bc_s   = '{bc_f, bc_r};
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pb%0d", i), 32'(pb_s[i]), 32'(m_pb[i]));
            chk($sformatf("busy%0d", i), 32'(busy_s[i]), 32'(cyc < m_done_at[i]));
            chk($sformatf("done%0d", i), 32'(done_s[i]), 32'(cyc == m_done_at[i]));
            chk($sformatf("bounce_cnt%0d", i), 32'(bc_s[i]), 32'((m_togs[i] + 1) / 2));
            if (pb_s[i] !== pb_prev[i]) edges[i].push_back(cyc - start_at[i]);
            pb_prev[i] = pb_s[i];
            if (done_s[i] === 1'b1) begin
                done_n[i]++;
                done_cyc[i] = cyc;
            end
        end
    endtask

    task automatic tick();
        logic [15:0] lf;
        lf = m_lfsr;
        @(posedge clock);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_lfsr = lfsr_adv(m_lfsr);
            for (int i = 0; i < 2; i++) model_edge(i, lf);
        end
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("lfsr_rst", 32'(dut_fix.u_lfsr.state), 32'(SEED));
        repeat (5) tick();
        chk("lfsr_rst_hold", 32'(dut_rnd.u_lfsr.state), 32'(SEED));
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic tgt, input int nb, input int sl);
        start      = 1'b1;
        target     = tgt;
        n_bounce   = 4'(nb);
        settle_len = 16'(sl);
        tick();
        start = 1'b0;
    endtask

    // Run until both instances have completed; optionally poke inputs while busy.
    task automatic wait_idle(input bit spurious);
        int n = 0;
        while ((cyc <= m_done_at[0] || cyc <= m_done_at[1]) && n < 4000) begin
            if (spurious && cyc < m_done_at[0] && cyc < m_done_at[1]) begin
                start      = ($urandom_range(0, 5) == 0);
                target     = 1'($urandom_range(0, 1));
                n_bounce   = 4'($urandom_range(0, 15));
                settle_len = 16'($urandom_range(0, 200));
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        chk("idle_reached", 32'(busy_f | busy_r), 0);
    endtask

    task automatic check_fixed_run(input string tag);
        int exp_e [5] = '{0, 20, 40, 60, 80};
        chk({tag, "_edges"}, edges[0].size(), 5);
        for (int k = 0; k < 5 && k < edges[0].size(); k++)
            chk($sformatf("%s_edge%0d", tag, k), edges[0][k], exp_e[k]);
        chk({tag, "_done_t"}, done_cyc[0] - start_at[0], 181);
        chk({tag, "_done_n"}, done_n[0], 1);
        chk({tag, "_pb_end"}, 32'(pb_f), 1);
    endtask

    task automatic check_random_run(input bit compare_saved);
        int g;
        chk("rnd_edges", edges[1].size(), 31);
        chk("rnd_pb_end", 32'(pb_r), 1);
        for (int k = 1; k < edges[1].size(); k++) begin
            g = edges[1][k] - edges[1][k-1];
            chk("rnd_gap_range", 32'(g >= 20 && g <= 51), 1);
            if (compare_saved) begin
                if (k - 1 < saved_gaps.size())
                    chk($sformatf("rnd_repeat_gap%0d", k), g, saved_gaps[k-1]);
            end else begin
                saved_gaps.push_back(g);
            end
        end
        if (compare_saved) chk("rnd_repeat_len", edges[1].size() - 1, saved_gaps.size());
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();
        repeat (2) tick();

        // fixed-gap bounce, PB 0 -> 1
        issue(1'b1, 2, 100);
        wait_idle(1'b0);
        check_fixed_run("fix");

        // clean edge, PB 1 -> 0, settle_len 0 behaves as 1
        tick();
        issue(1'b0, 0, 0);
        wait_idle(1'b0);
        chk("clean_edges", edges[0].size(), 1);
        if (edges[0].size() > 0) chk("clean_edge_t", edges[0][0], 0);
        chk("clean_done_t", done_cyc[0] - start_at[0], 2);
        chk("clean_done_n", done_n[0], 1);

        // second start during the command must be ignored
        tick();
        issue(1'b1, 2, 100);
        repeat (29) tick();
        start  = 1'b1;
        target = 1'b0;
        tick();
        start = 1'b0;
        wait_idle(1'b0);
        check_fixed_run("ign");

        // random gaps, then repeat after reset
        do_reset();
        repeat (3) tick();
        issue(1'b1, 15, 10);
        wait_idle(1'b0);
        check_random_run(1'b0);
        do_reset();
        repeat (3) tick();
        issue(1'b1, 15, 10);
        wait_idle(1'b0);
        check_random_run(1'b1);

        // reset in the middle of a bounce
        tick();
        issue(1'b1, 15, 50);
        begin
            int n = 0;
            while ((m_togs[0] + 1) / 2 != 7 && n < 2000) begin
                tick();
                n++;
            end
        end
        chk("mid_bc_before", 32'(bc_f), 7);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("mid_pb_now", 32'(pb_f | pb_r), 0);
        chk("mid_busy_now", 32'(busy_f | busy_r), 0);
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("mid_no_done", done_n[0] + done_n[1], 0);
        issue(1'b1, 1, 5);
        wait_idle(1'b0);
        chk("mid_fresh_edges", edges[0].size(), 3);
        if (edges[0].size() == 3) chk("mid_fresh_edge2", edges[0][2], 40);
        chk("mid_fresh_done_t", done_cyc[0] - start_at[0], 46);

        // randomized commands with ignored starts and input churn while busy
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 4)) tick();
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 30)));
            wait_idle(1'b1);
            chk("rnd_cmd_done_n", done_n[0] + done_n[1], 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
